// File: rtl/gpo_pad_ctrl.sv
// rtl/gpo_pad_ctrl.sv - core-side controller for one general-purpose output pad
module gpo_pad_ctrl #(
    parameter int OFF_CYCLES    = 4,
    parameter int SETTLE_CYCLES = 8,
    parameter int CNT_W         = 8
) (
    input  logic       CLK_I,
    input  logic       RST_I,
    input  logic       DATA_I,
    input  logic       OE_REQ_I,
    input  logic       CFG_VALID_I,
    output logic       CFG_READY_O,
    input  logic [1:0] CFG_DS_I,
    input  logic       CFG_SR_I,
    input  logic       CFG_CO_I,
    input  logic       CFG_ODP_I,
    input  logic       CFG_ODN_I,
    input  logic       VBIAS_OK_I,
    input  logic       CLR_ERR_I,
    output logic       DO_O,
    output logic       OE_O,
    output logic [1:0] DS_O,
    output logic       SR_O,
    output logic       CO_O,
    output logic       ODP_O,
    output logic       ODN_O,
    output logic       BUSY_O,
    output logic       BIAS_ERR_O
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        APPLY  = 2'd2,
        SETTLE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] OFF_LOAD    = CNT_W'(OFF_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             oe_d;
    logic             load_cfg;
    logic             apply_cfg;

    logic [1:0]       sh_ds;
    logic             sh_sr, sh_co, sh_odp, sh_odn;

    logic             vb_meta, vb_s;
    logic             bias_ok;
    logic             accept;
    logic             err_set;

    assign bias_ok     = (DS_O == 2'b00) | vb_s;
    assign CFG_READY_O = (state_q == RUN);
    assign BUSY_O      = (state_q != RUN);
    assign accept      = CFG_VALID_I & CFG_READY_O;
    assign err_set     = (state_q == RUN) & OE_REQ_I & ~bias_ok;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        oe_d      = 1'b0;
        load_cfg  = 1'b0;
        apply_cfg = 1'b0;
        case (state_q)
            RUN: begin
                if (accept) begin
                    load_cfg = 1'b1;
                    cnt_d    = OFF_LOAD;
                    state_d  = DRAIN;
                end else begin
                    oe_d = OE_REQ_I & bias_ok;
                end
            end
            DRAIN: begin
                // New config is registered on the edge into APPLY so it is
                // already on the pad for the whole APPLY cycle.
                if (cnt_q == '0) begin
                    apply_cfg = 1'b1;
                    state_d   = APPLY;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            APPLY: begin
                cnt_d   = SETTLE_LOAD;
                state_d = SETTLE;
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    oe_d    = OE_REQ_I & bias_ok;
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q    <= RUN;
            cnt_q      <= '0;
            vb_meta    <= 1'b0;
            vb_s       <= 1'b0;
            sh_ds      <= 2'b00;
            sh_sr      <= 1'b0;
            sh_co      <= 1'b0;
            sh_odp     <= 1'b0;
            sh_odn     <= 1'b0;
            DO_O       <= 1'b0;
            OE_O       <= 1'b0;
            DS_O       <= 2'b00;
            SR_O       <= 1'b0;
            CO_O       <= 1'b0;
            ODP_O      <= 1'b0;
            ODN_O      <= 1'b0;
            BIAS_ERR_O <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vb_meta <= VBIAS_OK_I;
            vb_s    <= vb_meta;
            DO_O    <= DATA_I;
            OE_O    <= oe_d;
            if (load_cfg) begin
                sh_ds  <= CFG_DS_I;
                sh_sr  <= CFG_SR_I;
                sh_co  <= CFG_CO_I;
                sh_odp <= CFG_ODP_I;
                sh_odn <= CFG_ODN_I;
            end
            if (apply_cfg) begin
                DS_O  <= sh_ds;
                SR_O  <= sh_sr;
                CO_O  <= sh_co;
                ODP_O <= sh_odp;
                ODN_O <= sh_odn;
            end
            // Set wins over a simultaneous clear.
            BIAS_ERR_O <= err_set | (BIAS_ERR_O & ~CLR_ERR_I);
        end
    end

endmodule

// File: tb/tb_gpo_pad_ctrl.sv
// tb/tb_gpo_pad_ctrl.sv - scoreboard testbench for gpo_pad_ctrl
module tb_gpo_pad_ctrl;

    logic       CLK_I = 1'b0;
    logic       RST_I;
    logic       DATA_I;
    logic       OE_REQ_I;
    logic       CFG_VALID_I;
    logic       CFG_READY_O;
    logic [1:0] CFG_DS_I;
    logic       CFG_SR_I;
    logic       CFG_CO_I;
    logic       CFG_ODP_I;
    logic       CFG_ODN_I;
    logic       VBIAS_OK_I;
    logic       CLR_ERR_I;
    logic       DO_O;
    logic       OE_O;
    logic [1:0] DS_O;
    logic       SR_O;
    logic       CO_O;
    logic       ODP_O;
    logic       ODN_O;
    logic       BUSY_O;
    logic       BIAS_ERR_O;

    gpo_pad_ctrl #(
        .OFF_CYCLES   (4),
        .SETTLE_CYCLES(8),
        .CNT_W        (8)
    ) dut (
        .CLK_I      (CLK_I),
        .RST_I      (RST_I),
        .DATA_I     (DATA_I),
        .OE_REQ_I   (OE_REQ_I),
        .CFG_VALID_I(CFG_VALID_I),
        .CFG_READY_O(CFG_READY_O),
        .CFG_DS_I   (CFG_DS_I),
        .CFG_SR_I   (CFG_SR_I),
        .CFG_CO_I   (CFG_CO_I),
        .CFG_ODP_I  (CFG_ODP_I),
        .CFG_ODN_I  (CFG_ODN_I),
        .VBIAS_OK_I (VBIAS_OK_I),
        .CLR_ERR_I  (CLR_ERR_I),
        .DO_O       (DO_O),
        .OE_O       (OE_O),
        .DS_O       (DS_O),
        .SR_O       (SR_O),
        .CO_O       (CO_O),
        .ODP_O      (ODP_O),
        .ODN_O      (ODN_O),
        .BUSY_O     (BUSY_O),
        .BIAS_ERR_O (BIAS_ERR_O)
    );

    always #5 CLK_I = ~CLK_I;

    localparam logic [10:0] M_DO   = 11'h001;
    localparam logic [10:0] M_OE   = 11'h002;
    localparam logic [10:0] M_SR   = 11'h010;
    localparam logic [10:0] M_ERR  = 11'h100;
    localparam logic [10:0] M_BUSY = 11'h200;
    localparam logic [10:0] M_RDY  = 11'h400;
    localparam logic [10:0] M_CFG  = 11'h0FC;
    localparam logic [10:0] M_ALL  = 11'h7FF;

    typedef struct {
        int          cyc;
        logic [10:0] mask;
        logic [10:0] val;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    logic [10:0] cur_cfg = '0;

    logic [10:0] obs;
    assign obs = {CFG_READY_O, BUSY_O, BIAS_ERR_O, ODN_O, ODP_O, CO_O, SR_O, DS_O, OE_O, DO_O};

    always @(posedge CLK_I) cyc++;

    always @(negedge CLK_I) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            n_tests++;
            if (e.cyc < cyc) begin
                n_fail++;
                $display("FAIL %s: stale expectation for cycle %0d seen at cycle %0d", e.tag, e.cyc, cyc);
            end else if ((obs & e.mask) !== (e.val & e.mask)) begin
                n_fail++;
                $display("FAIL %s @cyc %0d: got %03h required %03h (mask %03h)",
                         e.tag, cyc, obs & e.mask, e.val & e.mask, e.mask);
            end
        end
    end

    function automatic logic [10:0] cfg_bits(input logic [1:0] ds, input logic sr, input logic co,
                                             input logic odp, input logic odn);
        return {3'b000, odn, odp, co, sr, ds, 2'b00};
    endfunction

    task automatic expect_at(input int c, input logic [10:0] mask, input logic [10:0] val, input string tag);
        exp_t e;
        int   i;
        e.cyc  = c;
        e.mask = mask;
        e.val  = val;
        e.tag  = tag;
        i = 0;
        while (i < sb.size() && sb[i].cyc <= c) i++;
        sb.insert(i, e);
    endtask

    task automatic tick();
        @(posedge CLK_I);
        #1;
    endtask

    task automatic drive_cfg(input logic [1:0] ds, input logic sr, input logic co,
                             input logic odp, input logic odn);
        CFG_DS_I  = ds;
        CFG_SR_I  = sr;
        CFG_CO_I  = co;
        CFG_ODP_I = odp;
        CFG_ODN_I = odn;
    endtask

    // Full reconfiguration with OE_REQ_I high and bias good; returns at accept+14.
    task automatic do_cfg(input logic [1:0] ds, input logic sr, input logic co,
                          input logic odp, input logic odn, input string tag);
        int          t;
        logic [10:0] nc;
        t  = cyc;
        nc = cfg_bits(ds, sr, co, odp, odn);
        CFG_VALID_I = 1'b1;
        drive_cfg(ds, sr, co, odp, odn);
        expect_at(t, M_RDY | M_BUSY, M_RDY, {tag, "_accept"});
        for (int k = 1; k <= 13; k++) begin
            expect_at(t + k, M_OE | M_BUSY | M_RDY, M_BUSY, {tag, "_window"});
            expect_at(t + k, M_CFG, (k < 5) ? cur_cfg : nc, {tag, "_cfg"});
        end
        expect_at(t + 14, M_OE | M_BUSY | M_RDY | M_CFG, M_OE | M_RDY | nc, {tag, "_reenable"});
        cur_cfg = nc;
        tick();
        CFG_VALID_I = 1'b0;
        repeat (13) tick();
    endtask

    initial begin
        logic [5:0] pat;
        int         t;
        int         guard;

        RST_I       = 1'b1;
        DATA_I      = 1'b0;
        OE_REQ_I    = 1'b0;
        CFG_VALID_I = 1'b0;
        drive_cfg(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        VBIAS_OK_I  = 1'b0;
        CLR_ERR_I   = 1'b0;

        tick();
        tick();
        expect_at(cyc, M_ALL, M_RDY, "reset_values");

        // Data pass-through and OE one cycle after reset release
        pat = 6'b101100;
        RST_I    = 1'b0;
        OE_REQ_I = 1'b1;
        for (int i = 0; i < 6; i++) begin
            DATA_I = pat[i];
            expect_at(cyc + 1, M_DO | M_OE | M_ERR | M_BUSY, {10'b0, pat[i]} | M_OE, "do_follow");
            tick();
        end

        VBIAS_OK_I = 1'b1;
        repeat (3) tick();
        do_cfg(2'b10, 1'b1, 1'b0, 1'b0, 1'b0, "cfg_ds10");

        // DS=11 with both drive sides disabled, then bias gating
        do_cfg(2'b11, 1'b0, 1'b1, 1'b1, 1'b1, "cfg_ds11_od");
        t = cyc;
        VBIAS_OK_I = 1'b0;
        expect_at(t + 2, M_OE | M_ERR, M_OE, "bias_drop_lat");
        expect_at(t + 3, M_OE | M_ERR, M_ERR, "bias_gated");
        repeat (5) tick();
        expect_at(cyc, M_OE | M_ERR, M_ERR, "bias_gated_hold");
        t = cyc;
        VBIAS_OK_I = 1'b1;
        expect_at(t + 2, M_OE | M_ERR, M_ERR, "bias_rise_lat");
        expect_at(t + 3, M_OE | M_ERR, M_OE | M_ERR, "bias_restored");
        repeat (3) tick();
        t = cyc;
        CLR_ERR_I = 1'b1;
        expect_at(t + 1, M_OE | M_ERR, M_OE, "err_clear");
        tick();
        CLR_ERR_I  = 1'b0;
        VBIAS_OK_I = 1'b0;
        expect_at(t + 3, M_ERR, 11'h000, "err_before_set");
        expect_at(t + 4, M_ERR, M_ERR, "err_set_beats_clr");
        tick();
        tick();
        CLR_ERR_I = 1'b1;
        tick();
        CLR_ERR_I  = 1'b0;
        VBIAS_OK_I = 1'b1;
        repeat (3) tick();
        CLR_ERR_I = 1'b1;
        expect_at(cyc + 1, M_ERR | M_OE, M_OE, "err_clear2");
        tick();
        CLR_ERR_I = 1'b0;

        // Valid held across a sequence: second config taken in first RUN cycle
        begin
            logic [10:0] nc1, nc2;
            t   = cyc;
            nc1 = cfg_bits(2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
            nc2 = cfg_bits(2'b10, 1'b1, 1'b0, 1'b0, 1'b0);
            CFG_VALID_I = 1'b1;
            drive_cfg(2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
            expect_at(t, M_RDY, M_RDY, "hold_accept1");
            for (int k = 1; k <= 13; k++) begin
                expect_at(t + k, M_OE | M_BUSY | M_RDY, M_BUSY, "hold_window1");
                expect_at(t + k, M_CFG, (k < 5) ? cur_cfg : nc1, "hold_cfg1");
            end
            expect_at(t + 14, M_OE | M_BUSY | M_RDY | M_CFG, M_OE | M_RDY | nc1, "hold_run_gap");
            for (int k = 15; k <= 27; k++) begin
                expect_at(t + k, M_OE | M_BUSY | M_RDY, M_BUSY, "hold_window2");
                expect_at(t + k, M_CFG, (k < 19) ? nc1 : nc2, "hold_cfg2");
            end
            expect_at(t + 28, M_OE | M_BUSY | M_RDY | M_CFG, M_OE | M_RDY | nc2, "hold_reenable2");
            tick();
            drive_cfg(2'b10, 1'b1, 1'b0, 1'b0, 1'b0);
            repeat (14) tick();
            CFG_VALID_I = 1'b0;
            repeat (13) tick();
            cur_cfg = nc2;
        end

        // Reset during SETTLE after DS=01 has been applied
        t = cyc;
        CFG_VALID_I = 1'b1;
        drive_cfg(2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        CFG_VALID_I = 1'b0;
        repeat (6) tick();
        expect_at(t + 7, M_BUSY | M_CFG | M_OE, M_BUSY | cfg_bits(2'b01, 1'b0, 1'b0, 1'b0, 1'b0), "settle_applied");
        RST_I  = 1'b1;
        DATA_I = 1'b0;
        expect_at(t + 8, M_ALL, M_RDY, "mid_seq_reset");
        tick();
        RST_I  = 1'b0;
        DATA_I = 1'b1;
        expect_at(t + 9, M_ALL, M_RDY | M_OE | M_DO, "after_reset_run");
        tick();
        cur_cfg = '0;

        // Identical config still runs the full sequence
        do_cfg(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, "cfg_same");

        guard = 0;
        while (sb.size() > 0 && guard < 50) begin
            tick();
            guard++;
        end
        @(negedge CLK_I);
        #1;
        if (sb.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
